// File: rtl/baud_tick_generator.sv
// Baud-rate tick generator: oversample tick (rx_tick), baud tick (tx_tick) and a
// 50% duty baud clock, with preset or custom divisors applied only on baud boundaries.
module baud_tick_generator #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int CNT_W       = 16,
  parameter int BAUD_0      = 4800,
  parameter int BAUD_1      = 9600,
  parameter int BAUD_2      = 57600,
  parameter int BAUD_3      = 115200
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       S,
  input  logic             use_custom,
  input  logic [CNT_W-1:0] div_custom,
  output logic             rx_tick,
  output logic             tx_tick,
  output logic             clk_out,
  output logic [2:0]       rate_active
);

  localparam int PH_W = $clog2(OVERSAMPLE);

  function automatic longint div_calc(input longint baud);
    longint span;
    span = baud * longint'(OVERSAMPLE);
    return (longint'(CLK_FREQ_HZ) + span / 64'sd2) / span;
  endfunction

  localparam longint DIV_0   = div_calc(longint'(BAUD_0));
  localparam longint DIV_1   = div_calc(longint'(BAUD_1));
  localparam longint DIV_2   = div_calc(longint'(BAUD_2));
  localparam longint DIV_3   = div_calc(longint'(BAUD_3));
  localparam longint DIV_LIM = 64'sd1 <<< CNT_W;

  localparam logic [CNT_W-1:0] DIV_0_C = CNT_W'(DIV_0);
  localparam logic [CNT_W-1:0] DIV_1_C = CNT_W'(DIV_1);
  localparam logic [CNT_W-1:0] DIV_2_C = CNT_W'(DIV_2);
  localparam logic [CNT_W-1:0] DIV_3_C = CNT_W'(DIV_3);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OVERSAMPLE - 32'sd1);
  localparam logic [PH_W-1:0]  PH_HALF = PH_W'(OVERSAMPLE / 32'sd2);

  if ((OVERSAMPLE < 32'sd4) || ((OVERSAMPLE % 32'sd2) != 32'sd0)) begin : g_bad_oversample
    $error("baud_tick_generator: OVERSAMPLE must be even and at least 4");
  end

  if ((DIV_0 < 64'sd2) || (DIV_0 >= DIV_LIM) || (DIV_1 < 64'sd2) || (DIV_1 >= DIV_LIM) ||
      (DIV_2 < 64'sd2) || (DIV_2 >= DIV_LIM) || (DIV_3 < 64'sd2) || (DIV_3 >= DIV_LIM))
  begin : g_bad_divisor
    $error("baud_tick_generator: preset divisor out of range for CNT_W");
  end

  // Requested divisor; custom values below 2 would stall the counter, so they clamp to 2.
  function automatic logic [CNT_W-1:0] divisor_of(input logic custom, input logic [1:0] sel,
                                                  input logic [CNT_W-1:0] div);
    logic [CNT_W-1:0] d;
    d = DIV_0_C;
    if (custom) begin
      if (div < CNT_W'(2)) d = CNT_W'(2);
      else                 d = div;
    end else begin
      case (sel)
        2'd0:    d = DIV_0_C;
        2'd1:    d = DIV_1_C;
        2'd2:    d = DIV_2_C;
        2'd3:    d = DIV_3_C;
        default: d = DIV_0_C;
      endcase
    end
    return d;
  endfunction

  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] div_r, div_s;
  logic [CNT_W-1:0] div_req_s;
  logic [PH_W-1:0]  phase_r, phase_s;
  logic             rx_tick_r, rx_tick_s;
  logic             tx_tick_r, tx_tick_s;
  logic             clk_out_r, clk_out_s;
  logic [2:0]       rate_r, rate_s;

  // Next-state: idle reloads with the requested rate, running counts down and
  // swaps the divisor only on the reload that wraps the phase.
  always_comb begin
    div_req_s = divisor_of(use_custom, S, div_custom);
    cnt_s     = cnt_r;
    div_s     = div_r;
    phase_s   = phase_r;
    rx_tick_s = 1'b0;
    tx_tick_s = 1'b0;
    clk_out_s = clk_out_r;
    rate_s    = rate_r;
    if (!en) begin
      cnt_s     = div_req_s - CNT_W'(1);
      div_s     = div_req_s;
      phase_s   = {PH_W{1'b0}};
      clk_out_s = 1'b0;
      rate_s    = {use_custom, S};
    end else if (cnt_r == {CNT_W{1'b0}}) begin
      rx_tick_s = 1'b1;
      if (phase_r == PH_LAST) begin
        tx_tick_s = 1'b1;
        phase_s   = {PH_W{1'b0}};
        div_s     = div_req_s;
        cnt_s     = div_req_s - CNT_W'(1);
        rate_s    = {use_custom, S};
      end else begin
        phase_s   = phase_r + PH_W'(1);
        cnt_s     = div_r - CNT_W'(1);
      end
      clk_out_s = (phase_s < PH_HALF);
    end else begin
      cnt_s     = cnt_r - CNT_W'(1);
      clk_out_s = (phase_r < PH_HALF);
    end
  end

  // State and output registers; reset parks on preset 0 with all outputs low.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_r     <= DIV_0_C - CNT_W'(1);
      div_r     <= DIV_0_C;
      phase_r   <= {PH_W{1'b0}};
      rx_tick_r <= 1'b0;
      tx_tick_r <= 1'b0;
      clk_out_r <= 1'b0;
      rate_r    <= 3'b000;
    end else begin
      cnt_r     <= cnt_s;
      div_r     <= div_s;
      phase_r   <= phase_s;
      rx_tick_r <= rx_tick_s;
      tx_tick_r <= tx_tick_s;
      clk_out_r <= clk_out_s;
      rate_r    <= rate_s;
    end
  end

  assign rx_tick     = rx_tick_r;
  assign tx_tick     = tx_tick_r;
  assign clk_out     = clk_out_r;
  assign rate_active = rate_r;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Self-checking bench for baud_tick_generator: directed scenarios plus random rates,
// checked against tick times derived arithmetically from the divisor rules.
module tb_baud_tick_generator;

  localparam int CLK_HZ = 100_000_000;
  localparam int OS     = 16;
  localparam int CW     = 16;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          en;
  logic [1:0]    S;
  logic          use_custom;
  logic [CW-1:0] div_custom;
  logic          rx_tick;
  logic          tx_tick;
  logic          clk_out;
  logic [2:0]    rate_active;

  int checks = 0;
  int errors = 0;

  baud_tick_generator #(
    .CLK_FREQ_HZ(CLK_HZ),
    .OVERSAMPLE (OS),
    .CNT_W      (CW)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .en         (en),
    .S          (S),
    .use_custom (use_custom),
    .div_custom (div_custom),
    .rx_tick    (rx_tick),
    .tx_tick    (tx_tick),
    .clk_out    (clk_out),
    .rate_active(rate_active)
  );

  always #5 clk_in = ~clk_in;

  function automatic int exp_div(input logic cu, input logic [1:0] s, input int dc);
    int baud;
    if (cu) return (dc < 2) ? 2 : dc;
    case (s)
      2'd0:    baud = 4800;
      2'd1:    baud = 9600;
      2'd2:    baud = 57600;
      default: baud = 115200;
    endcase
    return (CLK_HZ + baud * OS / 2) / (baud * OS);
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // k counts edges since en was sampled high (k=0 is a boundary re-origin).
  task automatic window(input int n, input int d, input int k_start, input logic [2:0] rate,
                        input string tag);
    for (int i = 0; i < n; i++) begin
      int   k;
      logic e_rx, e_tx, e_clk;
      @(posedge clk_in); #1;
      k     = k_start + i;
      e_rx  = ((k % d) == 0);
      e_tx  = ((k % (d * OS)) == 0);
      e_clk = (((k / d) % OS) < (OS / 2));
      chk($sformatf("%s_rx@%0d", tag, k), {2'b00, rx_tick}, {2'b00, e_rx});
      chk($sformatf("%s_tx@%0d", tag, k), {2'b00, tx_tick}, {2'b00, e_tx});
      chk($sformatf("%s_clk@%0d", tag, k), {2'b00, clk_out}, {2'b00, e_clk});
      chk($sformatf("%s_rate@%0d", tag, k), rate_active, rate);
    end
  endtask

  task automatic idle(input int n, input logic [2:0] rate, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in); #1;
      chk($sformatf("%s_rx%0d", tag, i), {2'b00, rx_tick}, 3'b000);
      chk($sformatf("%s_tx%0d", tag, i), {2'b00, tx_tick}, 3'b000);
      chk($sformatf("%s_clk%0d", tag, i), {2'b00, clk_out}, 3'b000);
      chk($sformatf("%s_rate%0d", tag, i), rate_active, rate);
    end
  endtask

  initial begin
    logic       r_cu;
    logic [1:0] r_s;
    int         r_dc, r_d, r_n;

    // Reset state
    reset = 1'b0; en = 1'b0; S = 2'b00; use_custom = 1'b0; div_custom = '0;
    #3;
    chk("rst_rx", {2'b00, rx_tick}, 3'b000);
    chk("rst_tx", {2'b00, tx_tick}, 3'b000);
    chk("rst_clk", {2'b00, clk_out}, 3'b000);
    chk("rst_rate", rate_active, 3'b000);
    @(posedge clk_in); #1;
    reset = 1'b1;
    idle(2, 3'b000, "post_rst");

    // Custom divisor 4: rx every 4, tx every 64, clk_out 32/32
    use_custom = 1'b1; div_custom = 16'd4;
    idle(1, 3'b100, "c4_apply");
    en = 1'b1;
    window(200, 4, 1, 3'b100, "c4");

    // Clamped divisors 0 and 1
    en = 1'b0; div_custom = 16'd0;
    idle(1, 3'b100, "c0_apply");
    en = 1'b1;
    window(70, 2, 1, 3'b100, "c0");
    en = 1'b0; div_custom = 16'd1;
    idle(1, 3'b100, "c1_apply");
    en = 1'b1;
    window(40, 2, 1, 3'b100, "c1");

    // Preset 115200 baud at 100 MHz
    en = 1'b0; use_custom = 1'b0; S = 2'b11;
    idle(1, 3'b011, "p3_apply");
    chk("p3_div", 3'(exp_div(1'b0, 2'b11, 0) == 54), 3'b001);
    en = 1'b1;
    window(1800, 54, 1, 3'b011, "p3");

    // Random rate selections
    for (int t = 0; t < 6; t++) begin
      r_cu = 1'($urandom_range(0, 1));
      r_s  = 2'($urandom_range(0, 3));
      r_dc = int'($urandom_range(0, 12));
      r_d  = exp_div(r_cu, r_s, r_dc);
      r_n  = r_cu ? (2 * OS * r_d + 5) : (3 * r_d + 5);
      en = 1'b0; use_custom = r_cu; S = r_s; div_custom = CW'(r_dc);
      idle(1, {r_cu, r_s}, $sformatf("rnd%0d_apply", t));
      en = 1'b1;
      window(r_n, r_d, 1, {r_cu, r_s}, $sformatf("rnd%0d", t));
    end

    // Rate change at phase 5 defers to the tx boundary
    en = 1'b0; use_custom = 1'b1; S = 2'b00; div_custom = 16'd4;
    idle(1, 3'b100, "chg_apply");
    en = 1'b1;
    window(20, 4, 1, 3'b100, "chg_pre");
    div_custom = 16'd6; S = 2'b01;
    window(43, 4, 21, 3'b100, "chg_old");
    window(200, 6, 0, 3'b101, "chg_new");

    // en drop at phase 9 with simultaneous rate change, restore after 10 cycles
    en = 1'b0;
    idle(1, 3'b101, "drop_apply");
    en = 1'b1;
    window(55, 6, 1, 3'b101, "drop_pre");
    en = 1'b0; div_custom = 16'd5; S = 2'b10;
    idle(10, 3'b110, "drop_idle");
    en = 1'b1;
    window(150, 5, 1, 3'b110, "drop_post");

    // Asynchronous reset mid-period while rx_tick is high
    window(35, 5, 151, 3'b110, "rst_pre");
    chk("rst_pre_tick", {2'b00, rx_tick}, 3'b001);
    #2;
    reset = 1'b0; en = 1'b0;
    #1;
    chk("arst_rx", {2'b00, rx_tick}, 3'b000);
    chk("arst_tx", {2'b00, tx_tick}, 3'b000);
    chk("arst_clk", {2'b00, clk_out}, 3'b000);
    chk("arst_rate", rate_active, 3'b000);
    @(posedge clk_in); #1;
    reset = 1'b1;
    chk("rel_rate", rate_active, 3'b000);
    idle(1, 3'b110, "rel_apply");
    en = 1'b1;
    window(30, 5, 1, 3'b110, "rel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_tick_generator.md
BAUD_TICK_GENERATOR -- requirements
Module: baud_tick_generator

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning the number of rx_tick pulses per baud period; legal values are even and at least 4.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the divisor counter and of div_custom.
REQ-004 SHALL have parameters BAUD_0, BAUD_1, BAUD_2 and BAUD_3, defaults 4800, 9600, 57600 and 115200, meaning the preset baud rates selected by S.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: tick generation enable.
REQ-008 SHALL have port S, input, 2 bits: preset rate select.
REQ-009 SHALL have port use_custom, input, 1 bit: when 1, div_custom overrides S.
REQ-010 SHALL have port div_custom, input, CNT_W bits: custom oversample divisor in clk_in cycles.
REQ-011 SHALL have port rx_tick, output, 1 bit: one-cycle pulse at the oversample rate.
REQ-012 SHALL have port tx_tick, output, 1 bit: one-cycle pulse at the baud rate.
REQ-013 SHALL have port clk_out, output, 1 bit: baud-rate square wave.
REQ-014 SHALL have port rate_active, output, 3 bits: the applied selection, as {use_custom, S}.

Function
REQ-015 SHALL compute preset divisors at elaboration: Dn = (CLK_FREQ_HZ + BAUDn*OVERSAMPLE/2) / (BAUDn*OVERSAMPLE), i.e. rounded to nearest.
REQ-016 SHALL raise an elaboration error if any Dn < 2 or any Dn >= 2^CNT_W.
REQ-017 SHALL take the custom divisor as D = div_custom, except that values 0 and 1 are clamped to 2.
REQ-018 SHALL generate rx_tick as follows: the down-counter holds D-1; it decrements each cycle en=1; on reaching 0 it reloads D-1, and rx_tick is registered high for exactly the following cycle. The rx_tick period is therefore exactly D cycles.
REQ-019 SHALL assert rx_tick for the first time on the D-th rising edge after en is first sampled 1.
REQ-020 SHALL keep a phase counter, 0..OVERSAMPLE-1, that increments on each rx_tick and wraps to 0.
REQ-021 SHALL assert tx_tick in the same cycle as the rx_tick that wraps phase from OVERSAMPLE-1 to 0. The tx_tick period is therefore D*OVERSAMPLE cycles.
REQ-022 SHALL drive clk_out registered: 1 while phase < OVERSAMPLE/2, otherwise 0, giving 50% duty cycle.
REQ-023 SHALL sample S, use_custom and div_custom every cycle but apply them only at a tx_tick boundary: the new D is loaded in place of the reload value of the wrapping rx_tick, and rate_active updates in the same cycle.
REQ-024 SHALL, while en=0, apply S, use_custom and div_custom on every cycle.
REQ-025 SHALL never produce a shortened or merged tick on a rate change.
REQ-026 SHALL, when en=0: hold counter=D-1 and phase=0, drive rx_tick=0, tx_tick=0 and clk_out=0, and discard any partial period.
REQ-027 SHALL, on deassertion of en mid-period, force rx_tick and tx_tick to 0 from the next cycle onward.
REQ-028 SHALL, on simultaneous rate change and en falling, let en take priority: counters are cleared and the new rate is applied immediately.

Reset
REQ-029 SHALL, while reset=0, asynchronously clear rx_tick, tx_tick, clk_out and phase to 0, set rate_active=3'b000, and load the counter with D0-1.
REQ-030 SHALL, after reset release, resume the REQ-018/REQ-019 behaviour from en sampled high; reset asserted mid-operation aborts the current period with no residual pulse.

Verification
REQ-031 SHALL be checked with: use_custom=1, div_custom=4, OVERSAMPLE=16, en=1 -> rx_tick every 4 cycles, first on the 4th edge; tx_tick every 64 cycles; clk_out high 32 cycles, low 32 cycles.
REQ-032 SHALL be checked with: div_custom=0, then div_custom=1 -> rx_tick period is 2 cycles in both cases.
REQ-033 SHALL be checked with: CLK_FREQ_HZ=100e6, S=2'b11, use_custom=0 -> D=54, rx_tick every 54 cycles, tx_tick every 864 cycles, rate_active=3'b011.
REQ-034 SHALL be checked with: div_custom=4, then S changed to custom divisor 6 at phase 5 -> the remaining ticks of the current period stay 4 cycles apart; after the tx_tick the period becomes 6; rate_active changes in the tx_tick cycle.
REQ-035 SHALL be checked with: en dropped at phase 9 and restored 10 cycles later -> no ticks while en=0, clk_out=0, and the first rx_tick comes D edges after restore with phase restarting at 0.
REQ-036 SHALL be checked with: reset pulsed low mid-period -> all outputs 0 immediately (asynchronously), rate_active=3'b000, and no tick until D edges after release with en=1.
